// File: rtl/vliw_pkg.sv
// Shared types and constants for the VLIW bundle loader.
package vliw_pkg;

    localparam int unsigned SLOT_W = 32;
    localparam int unsigned NSLOT  = 8;

    localparam logic [SLOT_W-1:0] NOP = '0;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        COMMIT,
        FIN,
        DONE
    } loader_state_e;

endpackage

// File: rtl/bundle_packer.sv
// Slot counter plus insert buffer: slot 0 lands in the MSBs, clear refills the buffer with NOPs.
module bundle_packer
    import vliw_pkg::*;
#(
    parameter int unsigned SLOT_W = 32,
    parameter int unsigned NSLOT  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    push,
    input  logic [SLOT_W-1:0]       data,
    output logic [NSLOT*SLOT_W-1:0] slots,
    output logic                    last_slot
);

    localparam int unsigned CW = (NSLOT > 1) ? $clog2(NSLOT) : 1;

    logic [CW-1:0]           cnt_q, cnt_d;
    logic [NSLOT*SLOT_W-1:0] slots_q, slots_d;

    always_comb begin
        cnt_d   = cnt_q;
        slots_d = slots_q;
        if (clr) begin
            cnt_d   = '0;
            slots_d = {NSLOT{SLOT_W'(NOP)}};
        end else if (push) begin
            cnt_d = cnt_q + CW'(1);
            for (int k = 0; k < int'(NSLOT); k++) begin
                if (cnt_q == CW'(k)) begin
                    slots_d[(NSLOT-1-k)*SLOT_W +: SLOT_W] = data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            slots_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            slots_q <= slots_d;
        end
    end

    // High while the next accepted word completes the bundle.
    assign last_slot = (cnt_q == CW'(NSLOT - 1));
    assign slots     = slots_q;

endmodule

// File: rtl/vliw_bundle_loader.sv
// Packs a valid/ready stream of slot words into VLIW bundles and writes them to instruction memory.
// Define VLIW_NOP_PAD_EN to add in_last, which closes a bundle early with NOP-filled tail slots.
module vliw_bundle_loader
    import vliw_pkg::*;
#(
    parameter int unsigned SLOT_W      = vliw_pkg::SLOT_W,
    parameter int unsigned NSLOT       = vliw_pkg::NSLOT,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned ADDR_STRIDE = 8,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [CNT_W-1:0]        n_bundles,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SLOT_W-1:0]       in_data,
`ifdef VLIW_NOP_PAD_EN
    input  logic                    in_last,
`endif
    output logic                    imem_we,
    output logic [ADDR_W-1:0]       imem_addr,
    output logic [NSLOT*SLOT_W-1:0] imem_wdata,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_W-1:0]        bundle_cnt
);

    loader_state_e           state_q, state_d;
    logic [ADDR_W-1:0]       base_q, base_d, addr_q, commit_addr;
    logic [CNT_W-1:0]        n_q, n_d, cnt_q, cnt_d;
    logic [NSLOT*SLOT_W-1:0] wdata_q, slots;
    logic                    accept, last_slot, clr, end_bundle;

    // Gating on state keeps X on in_valid/in_data outside FILL harmless.
    assign accept = in_valid && (state_q == FILL);

`ifdef VLIW_NOP_PAD_EN
    assign end_bundle = accept && (last_slot || in_last);
`else
    assign end_bundle = accept && last_slot;
`endif

    assign commit_addr = base_q + ADDR_W'(cnt_q) * ADDR_W'(ADDR_STRIDE);

    bundle_packer #(
        .SLOT_W (SLOT_W),
        .NSLOT  (NSLOT)
    ) u_packer (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .push      (accept),
        .data      (in_data),
        .slots     (slots),
        .last_slot (last_slot)
    );

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        n_d      = n_q;
        cnt_d    = cnt_q;
        clr      = 1'b0;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    base_d = base_addr;
                    n_d    = n_bundles;
                    cnt_d  = '0;
                    if (n_bundles != '0) begin
                        state_d = FILL;
                        clr     = 1'b1;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            FILL: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (end_bundle) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                busy  = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
                // One extra bit so the compare cannot overflow at the counter limit.
                if (({1'b0, cnt_q} + (CNT_W+1)'(1)) < {1'b0, n_q}) begin
                    state_d = FILL;
                    clr     = 1'b1;
                end else begin
                    state_d = FIN;
                end
            end
            FIN: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            n_q     <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            if (state_q == COMMIT) begin
                addr_q  <= commit_addr;
                wdata_q <= slots;
            end
        end
    end

    // Write port shows the live bundle during COMMIT and holds it afterwards.
    assign imem_we    = (state_q == COMMIT);
    assign imem_addr  = imem_we ? commit_addr : addr_q;
    assign imem_wdata = imem_we ? slots : wdata_q;
    assign bundle_cnt = cnt_q;

endmodule
